// File: rtl/mist1032isa_sync_fifo_ram.sv
// Storage array for mist1032isa_sync_fifo: DEPTH x N, one synchronous write port
// and one asynchronous (show-ahead) read port. Contents are never reset.
module mist1032isa_sync_fifo_ram #(
    parameter int N     = 16,
    parameter int DEPTH = 16,
    parameter int D_N   = 4
) (
    input  logic           iCLOCK,
    input  logic           iWE,
    input  logic [D_N-1:0] iWADDR,
    input  logic [N-1:0]   iWDATA,
    input  logic [D_N-1:0] iRADDR,
    output logic [N-1:0]   oRDATA
);

    logic [N-1:0] mem_q [DEPTH];

    always_ff @(posedge iCLOCK) begin
        if (iWE) begin
            mem_q[iWADDR] <= iWDATA;
        end
    end

    assign oRDATA = mem_q[iRADDR];

endmodule

// File: rtl/mist1032isa_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and threshold flags.
// Define MIST1032ISA_SYNC_FIFO_ERROR_EN to build sticky overflow/underflow flags.
module mist1032isa_sync_fifo #(
    parameter int N        = 16,
    parameter int DEPTH    = 16,
    parameter int D_N      = 4,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic         iCLOCK,
    input  logic         iRESET_SYNC,
    input  logic         iREMOVE,
    input  logic         iWR_EN,
    input  logic [N-1:0] iWR_DATA,
    output logic         oWR_FULL,
    output logic         oWR_ALMOST_FULL,
    input  logic         iRD_EN,
    output logic [N-1:0] oRD_DATA,
    output logic         oRD_EMPTY,
    output logic         oRD_ALMOST_EMPTY,
    output logic [D_N:0] oCOUNT,
    output logic         oOVERFLOW,
    output logic         oUNDERFLOW
);

    localparam logic [D_N:0] FULL_CNT = (D_N+1)'(DEPTH);
    localparam logic [D_N:0] AF_CNT   = (D_N+1)'(AF_LEVEL);
    localparam logic [D_N:0] AE_CNT   = (D_N+1)'(AE_LEVEL);
    localparam logic [D_N:0] PTR_ONE  = (D_N+1)'(1);

    logic [D_N:0] wr_ptr_q, wr_ptr_d;
    logic [D_N:0] rd_ptr_q, rd_ptr_d;
    logic [D_N:0] count;
    logic         full, empty;
    logic         wr_acc, rd_acc;

    // Extra pointer bit distinguishes full from empty, so all DEPTH entries are usable.
    assign count  = wr_ptr_q - rd_ptr_q;
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign wr_acc = iWR_EN && !full;
    assign rd_acc = iRD_EN && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (iREMOVE) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    mist1032isa_sync_fifo_ram #(
        .N     (N),
        .DEPTH (DEPTH),
        .D_N   (D_N)
    ) u_ram (
        .iCLOCK (iCLOCK),
        .iWE    (wr_acc && !iREMOVE && !iRESET_SYNC),
        .iWADDR (wr_ptr_q[D_N-1:0]),
        .iWDATA (iWR_DATA),
        .iRADDR (rd_ptr_q[D_N-1:0]),
        .oRDATA (oRD_DATA)
    );

    assign oWR_FULL         = full;
    assign oWR_ALMOST_FULL  = (count >= AF_CNT);
    assign oRD_EMPTY        = empty;
    assign oRD_ALMOST_EMPTY = (count <= AE_CNT);
    assign oCOUNT           = count;

`ifdef MIST1032ISA_SYNC_FIFO_ERROR_EN
    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q || (iWR_EN && full);
        unf_d = unf_q || (iRD_EN && empty);
        if (iREMOVE) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign oOVERFLOW  = ovf_q;
    assign oUNDERFLOW = unf_q;
`else
    assign oOVERFLOW  = 1'b0;
    assign oUNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_mist1032isa_sync_fifo.sv
// Randomized bench for mist1032isa_sync_fifo against a queue-based reference model.
module tb_mist1032isa_sync_fifo;

    localparam int N = 16;
    localparam int DEPTH = 16;
    localparam int D_N = 4;

    logic         clk = 1'b0;
    logic         rst, rm, wr, rd;
    logic [N-1:0] wd;
    logic         full, afull, empty, aempty, ovf, unf;
    logic [N-1:0] rdata;
    logic [D_N:0] cnt;

    int n_chk = 0;
    int n_fail = 0;
    bit checking = 1'b0;

    int unsigned q[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    always #5 clk = ~clk;

    mist1032isa_sync_fifo #(
        .N(N), .DEPTH(DEPTH), .D_N(D_N), .AF_LEVEL(12), .AE_LEVEL(2)
    ) dut (
        .iCLOCK(clk), .iRESET_SYNC(rst), .iREMOVE(rm),
        .iWR_EN(wr), .iWR_DATA(wd), .oWR_FULL(full), .oWR_ALMOST_FULL(afull),
        .iRD_EN(rd), .oRD_DATA(rdata), .oRD_EMPTY(empty), .oRD_ALMOST_EMPTY(aempty),
        .oCOUNT(cnt), .oOVERFLOW(ovf), .oUNDERFLOW(unf)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update: rules of acceptance applied to the occupancy queue.
    task automatic model_edge(input bit r, input bit m, input bit w, input int unsigned d, input bit p);
        int sz;
        sz = q.size();
        if (r) begin
            q.delete(); m_ovf = 0; m_unf = 0;
        end else if (m) begin
            q.delete(); m_ovf = 0; m_unf = 0;
        end else begin
`ifdef MIST1032ISA_SYNC_FIFO_ERROR_EN
            if (w && sz == DEPTH) m_ovf = 1;
            if (p && sz == 0) m_unf = 1;
`endif
            if (p && sz > 0) void'(q.pop_front());
            if (w && sz < DEPTH) q.push_back(d);
        end
    endtask

    // Drive at negedge, let the edge happen, return at next negedge.
    task automatic step(input bit r, input bit m, input bit w, input int unsigned d, input bit p);
        rst = r; rm = m; wr = w; wd = N'(d); rd = p;
        @(posedge clk);
        model_edge(r, m, w, d, p);
        @(negedge clk);
        rst = 0; rm = 0; wr = 0; rd = 0;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            chk("count", cnt, q.size());
            chk("empty", empty, q.size() == 0);
            chk("full", full, q.size() == DEPTH);
            chk("almost_full", afull, q.size() >= 12);
            chk("almost_empty", aempty, q.size() <= 2);
            chk("overflow", ovf, m_ovf);
            chk("underflow", unf, m_unf);
            if (q.size() > 0) chk("rd_data", rdata, q[0]);
        end
    end

    initial begin
        rst = 1; rm = 0; wr = 0; rd = 0; wd = '0;
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        checking = 1'b1;
        @(negedge clk);
        chk("reset_count", cnt, 0);
        chk("reset_empty", empty, 1);
        chk("reset_aempty", aempty, 1);

        // Fill with 0..15, watching thresholds on the way.
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, i, 0);
            if (i == 1) chk("ae_at_2", aempty, 1);
            if (i == 2) chk("ae_at_3", aempty, 0);
            if (i == 10) chk("af_at_11", afull, 0);
            if (i == 11) chk("af_at_12", afull, 1);
        end
        chk("fill_full", full, 1);
        chk("fill_count", cnt, 16);

        // Full with write and read: read wins, write dropped.
        step(0, 0, 1, 16'h5555, 1);
        chk("full_wr_rd_count", cnt, 15);
        chk("full_wr_rd_head", rdata, 1);
        step(0, 0, 1, 16'h0010, 0);
        step(0, 0, 1, 16'h7777, 0);
        chk("ovf_after_full_write", ovf,
`ifdef MIST1032ISA_SYNC_FIFO_ERROR_EN
            1
`else
            0
`endif
        );

        // Drain in order.
        for (int i = 1; i <= 16; i++) begin
            chk("drain_data", rdata, i);
            step(0, 0, 0, 0, 1);
        end
        chk("drain_empty", empty, 1);

        // Empty with write and read: write wins.
        step(0, 0, 1, 16'hBEEF, 1);
        chk("empty_wr_rd_count", cnt, 1);
        chk("empty_wr_rd_data", rdata, 16'hBEEF);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Wrap: hold count near 5 while streaming 40 words.
        for (int i = 0; i < 5; i++) step(0, 0, 1, 16'h1000 + i, 0);
        for (int i = 5; i < 45; i++) step(0, 0, 1, 16'h1000 + i, 1);
        chk("wrap_count", cnt, 5);
        chk("wrap_head", rdata, 16'h1000 + 40);

        // Remove at count 7 with concurrent requests.
        step(0, 0, 1, 16'h2000, 0);
        step(0, 0, 1, 16'h2001, 0);
        chk("pre_remove_count", cnt, 7);
        step(0, 1, 1, 16'h2222, 1);
        chk("remove_count", cnt, 0);
        chk("remove_empty", empty, 1);

        // Randomized traffic with rare flush and reset.
        for (int i = 0; i < 1500; i++) begin
            int unsigned r;
            bit br, bm, bw, bp;
            r  = $urandom_range(0, 999);
            br = (r < 5);
            bm = (r >= 5 && r < 15);
            bw = ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 65 : 35));
            bp = ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 35 : 65));
            step(br, bm, bw, $urandom_range(0, 65535), bp);
        end

        // Reset in the middle of a write burst.
        for (int i = 0; i < 6; i++) step(0, 0, 1, 16'h3000 + i, 0);
        step(1, 0, 1, 16'h3FFF, 1);
        chk("midburst_reset_count", cnt, 0);
        chk("midburst_reset_empty", empty, 1);
        chk("midburst_reset_full", full, 0);
        chk("midburst_reset_afull", afull, 0);
        chk("midburst_reset_ovf", ovf, 0);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mist1032isa_sync_fifo.md
MIST1032ISA_SYNC_FIFO -- requirements
Module: mist1032isa_sync_fifo

Interface
REQ-001 SHALL have parameter N, default 16, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 SHALL have parameter D_N, default 4, equal to log2(DEPTH).
REQ-004 SHALL have parameter AF_LEVEL, default 12, almost-full threshold in entries (1..DEPTH).
REQ-005 SHALL have parameter AE_LEVEL, default 2, almost-empty threshold in entries (0..DEPTH-1).
REQ-006 SHALL have port iCLOCK  input  1  sole clock; all state changes on its rising edge.
REQ-007 SHALL have port iRESET_SYNC  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port iREMOVE  input  1  synchronous flush of all entries.
REQ-009 SHALL have port iWR_EN  input  1  write request.
REQ-010 SHALL have port iWR_DATA  input  N  write data.
REQ-011 SHALL have port oWR_FULL  output  1  count == DEPTH.
REQ-012 SHALL have port oWR_ALMOST_FULL  output  1  count >= AF_LEVEL.
REQ-013 SHALL have port iRD_EN  input  1  read (pop) request.
REQ-014 SHALL have port oRD_DATA  output  N  head entry, show-ahead.
REQ-015 SHALL have port oRD_EMPTY  output  1  count == 0.
REQ-016 SHALL have port oRD_ALMOST_EMPTY  output  1  count <= AE_LEVEL.
REQ-017 SHALL have port oCOUNT  output  D_N+1  current occupancy, 0..DEPTH.
REQ-018 SHALL have ports oOVERFLOW and oUNDERFLOW  output  1 each  sticky error flags (see REQ-031).

Function
REQ-019 SHALL keep D_N+1-bit write and read pointers; entry address = pointer[D_N-1:0]; wrap modulo DEPTH.
REQ-020 SHALL derive count = wr_ptr - rd_ptr, D_N+1 bits; full at exactly DEPTH (no wasted entry).
REQ-021 SHALL accept a write iff iWR_EN && !oWR_FULL; store iWR_DATA at wr address and increment wr_ptr.
REQ-022 SHALL accept a read iff iRD_EN && !oRD_EMPTY; increment rd_ptr.
REQ-023 SHALL present oRD_DATA combinationally from memory at rd address, zero latency; valid only when !oRD_EMPTY.
REQ-024 SHALL write-to-read latency be 1 cycle: data written at edge k is visible on oRD_DATA, with oRD_EMPTY low, after edge k.
REQ-025 SHALL when full with iWR_EN && iRD_EN: accept read, reject write; count becomes DEPTH-1.
REQ-026 SHALL when empty with iWR_EN && iRD_EN: accept write, reject read; count becomes 1.
REQ-027 SHALL otherwise with simultaneous accepted read and write leave count unchanged.
REQ-028 SHALL on iREMOVE set both pointers to 0 that edge, ignoring iWR_EN/iRD_EN; memory contents unchanged.
REQ-029 SHALL drive all status outputs from registered pointers only (no input-to-status combinational path).

Reset
REQ-030 SHALL on iRESET_SYNC high at a rising edge clear pointers and error flags: oCOUNT=0, oRD_EMPTY=1, oRD_ALMOST_EMPTY=1, oWR_FULL=0, oWR_ALMOST_FULL=0 (AF_LEVEL>0), oOVERFLOW=0, oUNDERFLOW=0; reset has priority over iREMOVE and requests; memory not cleared, oRD_DATA undefined while empty.

Configuration
REQ-031 SHALL with macro MIST1032ISA_SYNC_FIFO_ERROR_EN defined: set oOVERFLOW on iWR_EN while full, set oUNDERFLOW on iRD_EN while empty; both hold until iRESET_SYNC or iREMOVE.
REQ-032 SHALL without MIST1032ISA_SYNC_FIFO_ERROR_EN: tie oOVERFLOW and oUNDERFLOW to 0, no flag registers; all other behaviour identical.

Structure
REQ-033 SHALL need no shared package; all sizing via parameters N, DEPTH, D_N, AF_LEVEL, AE_LEVEL.
REQ-034 SHALL place storage in sub-module mist1032isa_sync_fifo_ram (DEPTH x N, one synchronous write port, one asynchronous read port); pointers, flags and count stay in the top.

Verification (N=16, DEPTH=16, AF_LEVEL=12, AE_LEVEL=2)
REQ-035 SHALL cover fill/drain: write 0x0000..0x000F -> oWR_FULL=1 after 16th write, oCOUNT=16; read 16 -> data in order, oRD_EMPTY=1.
REQ-036 SHALL cover thresholds: oWR_ALMOST_FULL rises on count 12; oRD_ALMOST_EMPTY is high at counts 0..2 and low at count 3.
REQ-037 SHALL cover simultaneous ops: full plus wr+rd -> count 15, head advances, written word dropped; empty plus wr 0xBEEF+rd -> count 1, oRD_DATA=0xBEEF next cycle.
REQ-038 SHALL cover wrap: 40 interleaved writes/reads at count ~5 -> no data loss or reorder across pointer wrap.
REQ-039 SHALL cover iREMOVE at count 7 with concurrent wr/rd -> oCOUNT=0, oRD_EMPTY=1 next cycle; iRESET_SYNC mid-burst -> reset values of REQ-030.
REQ-040 SHALL cover errors with macro defined: write at full -> oOVERFLOW=1 and held; read at empty -> oUNDERFLOW=1; without macro both stay 0.
